// File: rtl/byte_lane_memory.sv
`default_nettype none
// ============================================================================
//  Module   : byte_lane_memory
//  Purpose  : Byte-addressable RAM with DATA_BYTES lanes per access, misaligned
//             and wrapping addresses, RD_LAT-cycle read pipeline and an
//             in-order response FIFO of depth RD_LAT+1 with backpressure.
//  Options  : define BYTE_LANE_MEMORY_STATS_EN to add rd_count/wr_count ports.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_lane_memory #(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_BYTES-1:0]   req_be,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*DATA_BYTES-1:0] rsp_rdata
`ifdef BYTE_LANE_MEMORY_STATS_EN
    ,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
`endif
);

    localparam int c_DEPTH = RD_LAT + 1;
    localparam int c_PTR_W = $clog2(c_DEPTH);
    localparam int c_CNT_W = $clog2(c_DEPTH + 1);
    localparam int c_DW    = 8 * DATA_BYTES;

    logic [7:0]         r_mem [0:(2**ADDR_W)-1];

    logic [RD_LAT-1:0]  r_pipe_vld_q, w_pipe_vld_d;
    logic [c_DW-1:0]    r_pipe_dat_q [RD_LAT];
    logic [c_DW-1:0]    w_pipe_dat_d [RD_LAT];
    logic [c_DW-1:0]    r_fifo_q     [c_DEPTH];
    logic [c_DW-1:0]    w_fifo_d     [c_DEPTH];
    logic [c_PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [c_PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [c_CNT_W-1:0] r_out_q, w_out_d;

    logic               w_req_fire, w_wr_fire, w_rd_fire, w_rsp_fire, w_push;
    logic [ADDR_W-1:0]  w_lane_addr [DATA_BYTES];
    logic [c_DW-1:0]    w_rd_data;

    // Handshakes and externally visible outputs (forced to zero during reset).
    always_comb begin
        req_ready  = !rst && (r_out_q < c_CNT_W'(c_DEPTH));
        rsp_valid  = !rst && (r_cnt_q != '0);
        rsp_rdata  = rsp_valid ? r_fifo_q[r_rptr_q] : '0;
        w_req_fire = req_valid && req_ready;
        w_wr_fire  = w_req_fire && req_we;
        w_rd_fire  = w_req_fire && !req_we;
        w_rsp_fire = rsp_valid && rsp_ready;
        w_push     = r_pipe_vld_q[RD_LAT-1];
    end

    // Per-lane byte addresses wrap naturally at the top of memory.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_lane_addr[i]       = req_addr + ADDR_W'(i);
            w_rd_data[8*i +: 8]  = r_mem[w_lane_addr[i]];
        end
    end

    // Byte-enabled storage write on an accepted write request.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (req_be[i]) begin
                    r_mem[w_lane_addr[i]] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Next-state for read pipeline, response FIFO and outstanding count.
    always_comb begin
        w_pipe_vld_d    = r_pipe_vld_q;
        w_pipe_dat_d    = r_pipe_dat_q;
        w_pipe_vld_d[0] = w_rd_fire;
        w_pipe_dat_d[0] = w_rd_data;
        for (int i = 1; i < RD_LAT; i++) begin
            w_pipe_vld_d[i] = r_pipe_vld_q[i-1];
            w_pipe_dat_d[i] = r_pipe_dat_q[i-1];
        end
        w_fifo_d = r_fifo_q;
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        if (w_push) begin
            w_fifo_d[r_wptr_q] = r_pipe_dat_q[RD_LAT-1];
            w_wptr_d = (r_wptr_q == c_PTR_W'(c_DEPTH - 1)) ? '0 : r_wptr_q + c_PTR_W'(1);
        end
        if (w_rsp_fire) begin
            w_rptr_d = (r_rptr_q == c_PTR_W'(c_DEPTH - 1)) ? '0 : r_rptr_q + c_PTR_W'(1);
        end
        // The outstanding count bounds pipeline+FIFO, so a push never hits a full FIFO.
        w_cnt_d = r_cnt_q + c_CNT_W'(w_push)    - c_CNT_W'(w_rsp_fire);
        w_out_d = r_out_q + c_CNT_W'(w_rd_fire) - c_CNT_W'(w_rsp_fire);
    end

    // Control state; reset discards any in-flight or queued reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld_q <= '0;
            r_wptr_q     <= '0;
            r_rptr_q     <= '0;
            r_cnt_q      <= '0;
            r_out_q      <= '0;
        end else begin
            r_pipe_vld_q <= w_pipe_vld_d;
            r_wptr_q     <= w_wptr_d;
            r_rptr_q     <= w_rptr_d;
            r_cnt_q      <= w_cnt_d;
            r_out_q      <= w_out_d;
        end
    end

    // Data registers need no reset; their valid flags qualify them.
    always_ff @(posedge clk) begin
        r_pipe_dat_q <= w_pipe_dat_d;
        r_fifo_q     <= w_fifo_d;
    end

`ifdef BYTE_LANE_MEMORY_STATS_EN
    logic [31:0] r_rd_count_q, w_rd_count_d;
    logic [31:0] r_wr_count_q, w_wr_count_d;

    // Saturating access counters.
    always_comb begin
        w_rd_count_d = r_rd_count_q;
        w_wr_count_d = r_wr_count_q;
        if (w_rd_fire && (r_rd_count_q != 32'hFFFF_FFFF)) w_rd_count_d = r_rd_count_q + 32'd1;
        if (w_wr_fire && (r_wr_count_q != 32'hFFFF_FFFF)) w_wr_count_d = r_wr_count_q + 32'd1;
    end

    // Counter registers cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count_q <= '0;
            r_wr_count_q <= '0;
        end else begin
            r_rd_count_q <= w_rd_count_d;
            r_wr_count_q <= w_wr_count_d;
        end
    end

    assign rd_count = r_rd_count_q;
    assign wr_count = r_wr_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_lane_memory
//  Purpose  : Scoreboard bench for byte_lane_memory (RD_LAT=1 and RD_LAT=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_lane_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 0, req_we = 0, rsp_ready = 1;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        req_ready, rsp_valid;
    logic [15:0] rsp_rdata;

    logic        req_valid2 = 0, req_we2 = 0, rsp_ready2 = 1;
    logic [15:0] req_addr2 = '0, req_wdata2 = '0;
    logic [1:0]  req_be2 = '0;
    logic        req_ready2, rsp_valid2;
    logic [15:0] rsp_rdata2;

`ifdef BYTE_LANE_MEMORY_STATS_EN
    logic [31:0] rd_count, wr_count, rd_count2, wr_count2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb1 [$];
    logic [15:0] sb2 [$];

    always #5 clk = ~clk;

    byte_lane_memory #(.DATA_BYTES(2), .ADDR_W(16), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata)
`ifdef BYTE_LANE_MEMORY_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    byte_lane_memory #(.DATA_BYTES(2), .ADDR_W(16), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .req_be(req_be2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2)
`ifdef BYTE_LANE_MEMORY_STATS_EN
        , .rd_count(rd_count2), .wr_count(wr_count2)
`endif
    );

    // Response monitors: pop the scoreboard whenever a response is taken.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (sb1.size() == 0) begin
                n_errors++;
                $display("FAIL rsp1_unexpected: got %h, required no response", rsp_rdata);
            end else begin
                logic [15:0] e;
                e = sb1.pop_front();
                if (rsp_rdata !== e) begin
                    n_errors++;
                    $display("FAIL rsp1_data: got %h, required %h", rsp_rdata, e);
                end
            end
        end
        if (rsp_valid2 && rsp_ready2) begin
            n_checks++;
            if (sb2.size() == 0) begin
                n_errors++;
                $display("FAIL rsp2_unexpected: got %h, required no response", rsp_rdata2);
            end else begin
                logic [15:0] e;
                e = sb2.pop_front();
                if (rsp_rdata2 !== e) begin
                    n_errors++;
                    $display("FAIL rsp2_data: got %h, required %h", rsp_rdata2, e);
                end
            end
        end
    end

    // Present one request to DUT sel (1 or 2), wait for acceptance, log reads.
    task automatic issue(input int sel, input logic we, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wd, input logic [15:0] exp);
        logic done;
        done = 1'b0;
        if (sel == 1) begin
            req_valid = 1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
        end else begin
            req_valid2 = 1; req_we2 = we; req_addr2 = addr; req_be2 = be; req_wdata2 = wd;
        end
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if ((sel == 1) ? req_ready : req_ready2) begin
                done = 1'b1;
                if (!we) begin
                    if (sel == 1) sb1.push_back(exp);
                    else          sb2.push_back(exp);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 0; req_valid2 = 0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL issue_timeout: dut%0d addr %h accepted=%0b, required 1", sel, addr, done);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (sb1.size() != 0 || sb2.size() != 0); t++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (sb1.size() != 0 || sb2.size() != 0) begin
            n_errors++;
            $display("FAIL drain: pending %0d/%0d, required 0/0", sb1.size(), sb2.size());
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h, required 0 0 0000",
                     req_ready, rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || req_ready2 !== 1'b1 || rsp_valid2 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: ready=%b/%b valid=%b/%b, required 1/1 0/0",
                     req_ready, req_ready2, rsp_valid, rsp_valid2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        issue(1, 1, 16'd1000, 2'b11, 16'h0009, 16'h0);
        issue(1, 0, 16'd1000, 2'b00, 16'h0, 16'h0009);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: rsp_valid=%b, required 0", rsp_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0009) begin
            n_errors++;
            $display("FAIL latency_data: valid=%b rdata=%h, required 1 0009", rsp_valid, rsp_rdata);
        end
        drain();
    endtask

    task automatic test_byte_enable();
        issue(1, 1, 16'd1002, 2'b11, 16'h1234, 16'h0);
        issue(1, 1, 16'd1002, 2'b01, 16'hABCD, 16'h0);
        issue(1, 1, 16'd1002, 2'b00, 16'hFFFF, 16'h0);
        issue(1, 0, 16'd1002, 2'b00, 16'h0, 16'h12CD);
        issue(1, 0, 16'd1001, 2'b11, 16'h0, 16'hCD00);
        drain();
    endtask

    task automatic test_wrap();
        issue(1, 1, 16'h0000, 2'b10, 16'h5A00, 16'h0);
        issue(1, 1, 16'hFFFF, 2'b11, 16'hBEEF, 16'h0);
        issue(1, 0, 16'hFFFF, 2'b00, 16'h0, 16'hBEEF);
        issue(1, 0, 16'h0000, 2'b00, 16'h0, 16'h5ABE);
        drain();
    endtask

    // Continuous reads with random consumer stalls; push and pop often share an edge.
    task automatic test_stream();
        logic [15:0] addrs [3];
        logic [15:0] exps  [3];
        int k;
        addrs[0] = 16'd1000; exps[0] = 16'h0009;
        addrs[1] = 16'd1001; exps[1] = 16'hCD00;
        addrs[2] = 16'd1002; exps[2] = 16'h12CD;
        k = 0;
        for (int t = 0; t < 300 && k < 12; t++) begin
            req_valid = 1; req_we = 0; req_addr = addrs[k % 3];
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req_ready) begin
                sb1.push_back(exps[k % 3]);
                k++;
            end
            @(posedge clk); #1;
        end
        req_valid = 0;
        rsp_ready = 1;
        n_checks++;
        if (k != 12) begin
            n_errors++;
            $display("FAIL stream_accepts: got %0d, required 12", k);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        int acc;
        logic stalled_ready;
        vals[0] = 16'hA0A1; vals[1] = 16'hB0B1; vals[2] = 16'hC0C1; vals[3] = 16'hD0D1;
        for (int i = 0; i < 4; i++) issue(2, 1, 16'(2 * i), 2'b11, vals[i], 16'h0);
        rsp_ready2 = 0;
        acc = 0;
        stalled_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid2 = 1; req_we2 = 0; req_addr2 = 16'(2 * i);
            @(negedge clk);
            if (req_ready2) begin
                sb2.push_back(vals[i]);
                acc++;
            end else begin
                stalled_ready = req_ready2;
            end
            @(posedge clk); #1;
        end
        req_valid2 = 0;
        n_checks++;
        if (acc != 3 || stalled_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_accepts: got %0d ready=%b, required 3 ready=0", acc, stalled_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== 16'hA0A1 || req_ready2 !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_hold: valid=%b rdata=%h ready=%b, required 1 a0a1 0",
                         rsp_valid2, rsp_rdata2, req_ready2);
            end
        end
        @(posedge clk); #1;
        rsp_ready2 = 1;
        drain();
    endtask

    task automatic test_reset_mid();
        int rises;
        issue(1, 0, 16'd1000, 2'b00, 16'h0, 16'h0009);
        rst = 1;
        sb1.delete();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin
            n_errors++;
            $display("FAIL midrst_outputs: ready=%b valid=%b rdata=%h, required 0 0 0000",
                     req_ready, rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_ready: got %b, required 1", req_ready);
        end
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) rises++;
            @(negedge clk);
        end
        n_checks++;
        if (rises != 0) begin
            n_errors++;
            $display("FAIL midrst_discard: rsp_valid high %0d cycles, required 0", rises);
        end
        @(posedge clk); #1;
        // Storage survives reset.
        issue(1, 0, 16'd1000, 2'b00, 16'h0, 16'h0009);
        drain();
    endtask

`ifdef BYTE_LANE_MEMORY_STATS_EN
    task automatic test_stats();
        n_checks++;
        if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            n_errors++;
            $display("FAIL stats_start: rd=%0d wr=%0d, required 0 0", rd_count, wr_count);
        end
        for (int i = 0; i < 3; i++) issue(1, 1, 16'(3000 + 2 * i), 2'b11, 16'(16'h1111 * (i + 1)), 16'h0);
        for (int i = 0; i < 5; i++) issue(1, 0, 16'd1000, 2'b00, 16'h0, 16'h0009);
        drain();
        n_checks++;
        if (rd_count !== 32'd5 || wr_count !== 32'd3) begin
            n_errors++;
            $display("FAIL stats_count: rd=%0d wr=%0d, required 5 3", rd_count, wr_count);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            n_errors++;
            $display("FAIL stats_reset: rd=%0d wr=%0d, required 0 0", rd_count, wr_count);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_wrap();
        test_stream();
        test_back_to_back();
        test_reset_mid();
`ifdef BYTE_LANE_MEMORY_STATS_EN
        test_stats();
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
